// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding and instruction constants for the fetch sequencer
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] INSN_NOP    = 32'h00000013;
    localparam logic [31:0] INSN_EBREAK = 32'h00100073;

    // Byte stride between consecutive instruction words
    localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/fetch_perf_counter.sv
// rtl/fetch_perf_counter.sv - 16-bit saturating event counter with enable
module fetch_perf_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] count
);

    logic [15:0] count_q;
    logic [15:0] count_d;

    // Count enabled events, sticking at all-ones instead of wrapping
    always_comb begin
        count_d = count_q;
        if (en && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC owner and imem fetch sequencer; IFETCH_PERF_CNT_EN adds transfer/stall counters
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                 ADDR_W    = 8,
    parameter int                 DATA_W    = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter logic [DATA_W-1:0]  HALT_INSN = DATA_W'(INSN_EBREAK)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
`ifdef IFETCH_PERF_CNT_EN
    output logic [15:0]       fetch_count,
    output logic [15:0]       stall_count,
`endif
    output logic              halted
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_instr_q, out_instr_d;
    logic [ADDR_W-1:0] out_pc_q, out_pc_d;

    logic load;
    logic xfer;

    // A flush in the same cycle as out_ready discards the instruction, so it is not a transfer
    assign xfer = out_valid_q && out_ready && !redirect_valid;
    assign load = (state_q == ST_FETCH) && run_en && !redirect_valid
                  && (!out_valid_q || out_ready);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: redirect overrides everything, including HALT
    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = run_en ? ST_FETCH : ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (run_en) state_d = ST_FETCH;
                ST_FETCH: begin
                    if (!run_en) begin
                        state_d = ST_IDLE;
                    end else if (load && (imem_rdata == HALT_INSN)) begin
                        state_d = ST_HALT;
                    end
                end
                ST_HALT:  state_d = ST_HALT;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // State-decoded outputs
    always_comb begin
        halted = (state_q == ST_HALT);
    end

    // PC and output-slot update: flush on redirect, fill on load, drain on bare transfer
    always_comb begin
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        if (redirect_valid) begin
            pc_d        = {redirect_target[ADDR_W-1:2], 2'b00};
            out_valid_d = 1'b0;
        end else if (load) begin
            out_instr_d = imem_rdata;
            out_pc_d    = pc_q;
            out_valid_d = 1'b1;
            pc_d        = pc_q + ADDR_W'(PC_INC);
        end else if (xfer) begin
            out_valid_d = 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
        end else begin
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
        end
    end

    assign imem_addr = pc_q;
    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_pc    = out_pc_q;

`ifdef IFETCH_PERF_CNT_EN
    logic stall;
    assign stall = out_valid_q && !out_ready;

    fetch_perf_counter u_fetch_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (xfer),
        .count (fetch_count)
    );

    fetch_perf_counter u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (stall),
        .count (stall_count)
    );
`endif

endmodule
